player_score_tracker: RTL and testbench
=======================================

// Module: player_score_tracker
// PURPOSE
//  Producer side of the per-player score bus (p7..p0, 4-bit two's complement).
//  Tracks eight players' scores across a round from hit/miss events.
//  Presents frozen final scores with a round_done/ack handshake for the downstream summing logic.
//  Sits between the game input decoder and the score-combining adder chain.
// PARAMETERS
//  MAX_SCORE      2    upper saturation bound per player (signed, <= 7)
//  MIN_SCORE     -2    lower saturation bound per player (signed, >= -8, < MAX_SCORE)
//  ROUND_TIMEOUT  0    PLAY cycles before forced round end; 0 = disabled (16-bit count)
// PORTS
//  clk         in   1  clock, all state on posedge
//  reset_n     in   1  asynchronous, active-low reset
//  start       in   1  begin round (sampled in IDLE only)
//  player_sel  in   3  player index for this cycle's event (0 -> p0 .. 7 -> p7)
//  hit         in   1  +1 to selected player (PLAY only)
//  miss        in   1  -1 to selected player (PLAY only)
//  end_round   in   1  close round (PLAY only)
//  ack         in   1  consumer has taken scores (DONE only)
//  p7..p0      out  4  signed per-player scores, registered
//  busy        out  1  1 in PLAY
//  round_done  out  1  1 in DONE; scores stable while high
//  round_cnt   out  4  completed rounds, increments on ack, wraps 15 -> 0
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, p0..p7=0, busy=0, round_done=0, round_cnt=0, timeout count=0.
//  - FSM: IDLE -start-> PLAY; PLAY -end_round | timeout-> DONE; DONE -ack-> IDLE.
//  - IDLE->PLAY edge clears all scores to 0 and the timeout count; busy=1 next cycle.
//  - PLAY, one event per cycle:
//    - hit&!miss: score[player_sel] +1, saturating at MAX_SCORE.
//    - miss&!hit: score[player_sel] -1, saturating at MIN_SCORE.
//    - hit&miss: no change.
//  - Update visible on p* one cycle after the event edge.
//  - Arithmetic is 4-bit signed; saturation is checked before the write, so no wrap-around is ever stored.
//  - end_round with hit/miss in same cycle: the event is applied, then the FSM enters DONE.
//  - Timeout (ROUND_TIMEOUT>0): the count increments each PLAY cycle. When it reaches ROUND_TIMEOUT-1 with no
//    end_round, the next state is DONE. In-cycle event applied.
//  - DONE: round_done=1, busy=0, scores frozen; hit/miss/end_round/start ignored.
//  - ack in DONE: next cycle round_done=0, state IDLE, round_cnt+1 (mod 16). Scores are held, not cleared, in IDLE.
//  - ack outside DONE is ignored. start outside IDLE is ignored.
//  - reset_n asserted mid-round: immediate return to reset values; no round_done is produced.
// CONFIGURATION
//  - SCORE_STREAK_EN defined:
//    - A 2-bit streak counter is kept per player, cleared on start, on that player's miss, and on any other player's hit.
//    - The third and later consecutive hit by the same player adds +2 instead of +1, still saturating at MAX_SCORE.
//  - SCORE_STREAK_EN undefined: no streak state; every hit is +1.
// TESTING
//  - Reset -> all p*=0, busy=0, round_done=0, round_cnt=0; start -> busy=1 next cycle.
//  - PLAY: hit p3 x3, miss p0 x5 -> p3=2 (saturated at MAX), p0=-2 (4'b1110, saturated at MIN), others 0.
//  - hit&miss on p5 same cycle -> p5 unchanged; end_round+hit p7 same cycle -> p7=1, round_done=1, busy=0.
//  - In DONE, apply hit p1, start, end_round for 3 cycles -> all p* unchanged; then ack -> round_done=0
//    next cycle, round_cnt=1. After 16 rounds, round_cnt=0.
//  - ROUND_TIMEOUT=4: start, then no end_round -> round_done=1 four cycles after busy rose.
//    Reset mid-PLAY -> busy=0, p*=0 asynchronously.
//  - SCORE_STREAK_EN, MAX_SCORE=7: hit p2 x4 -> 1,2,4,6; then miss p2, hit p2 -> 5,6.

Source files
------------

// File: rtl/player_score_if.sv
// -----------------------------------------------------------------------------
// player_score_if
//   Groups the round-control inputs and the per-player score bus of
//   player_score_tracker.
//   master : the score tracker (drives p0..p7, busy, round_done, round_cnt)
//   slave  : the input decoder / downstream consumer side
// Signals
//   start, player_sel[2:0], hit, miss, end_round, ack   -> tracker
//   p0..p7[3:0] (signed), busy, round_done, round_cnt[3:0] <- tracker
// -----------------------------------------------------------------------------
interface player_score_if;
  logic       start;
  logic [2:0] player_sel;
  logic       hit;
  logic       miss;
  logic       end_round;
  logic       ack;
  logic [3:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic       busy;
  logic       round_done;
  logic [3:0] round_cnt;

  modport master (
    input  start, player_sel, hit, miss, end_round, ack,
    output p0, p1, p2, p3, p4, p5, p6, p7, busy, round_done, round_cnt
  );

  modport slave (
    output start, player_sel, hit, miss, end_round, ack,
    input  p0, p1, p2, p3, p4, p5, p6, p7, busy, round_done, round_cnt
  );
endinterface

// File: rtl/player_score_tracker.sv
// -----------------------------------------------------------------------------
// player_score_tracker
//   Tracks eight players' 4-bit signed scores across a round from hit/miss
//   events, then freezes them and offers them downstream with a
//   round_done/ack handshake.
//   FSM: IDLE -start-> PLAY -end_round|timeout-> DONE -ack-> IDLE.
// Ports
//   clk      : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : player_score_if.master (controls in, scores/status out)
// Parameters
//   MAX_SCORE / MIN_SCORE : saturation bounds (signed, MIN < MAX, in [-8,7])
//   ROUND_TIMEOUT         : PLAY cycles before forced round end, 0 = off
// Build option
//   SCORE_STREAK_EN : when defined, the third and later consecutive hit by
//                     the same player scores +2 instead of +1.
// -----------------------------------------------------------------------------
module player_score_tracker #(
  parameter int MAX_SCORE     = 2,
  parameter int MIN_SCORE     = -2,
  parameter int ROUND_TIMEOUT = 0
) (
  input logic            clk,
  input logic            reset_n,
  player_score_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bounds in a 6-bit signed domain so a sum one step past a bound is
  // still representable when compared, and in 4 bits for storing.
  localparam logic signed [5:0] MAX_W    = 6'(MAX_SCORE);
  localparam logic signed [5:0] MIN_W    = 6'(MIN_SCORE);
  localparam logic [3:0]        MAX_S    = 4'(MAX_SCORE);
  localparam logic [3:0]        MIN_S    = 4'(MIN_SCORE);
  localparam logic [15:0]       TMO_LAST = 16'(ROUND_TIMEOUT - 1);
  localparam bit                TMO_EN   = (ROUND_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [7:0][3:0]   score_q, score_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        cur_s;
  logic signed [5:0] cur_w;
  logic              inc_two;
  logic              hit_ev;
  logic              miss_ev;
`ifdef SCORE_STREAK_EN
  logic [7:0][1:0]   streak_q, streak_d;
`endif

  // hit and miss together cancel out.
  assign hit_ev  = bus.hit & ~bus.miss;
  assign miss_ev = bus.miss & ~bus.hit;
  assign cur_s   = score_q[bus.player_sel];
  assign cur_w   = {{2{cur_s[3]}}, cur_s};

`ifdef SCORE_STREAK_EN
  // Two earlier consecutive hits already recorded -> this is the third+.
  assign inc_two = (streak_q[bus.player_sel] >= 2'd2);
`else
  assign inc_two = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    score_d  = score_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
`ifdef SCORE_STREAK_EN
    streak_d = streak_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = PLAY;
          score_d  = '0;
          tmo_d    = '0;
`ifdef SCORE_STREAK_EN
          streak_d = '0;
`endif
        end
      end
      PLAY: begin
        tmo_d = tmo_q + 16'd1;
        if (hit_ev) begin
          // Bound checked before the write: the 4-bit sum is only stored
          // when it cannot have wrapped.
          if (cur_w + (inc_two ? 6'sd2 : 6'sd1) > MAX_W)
            score_d[bus.player_sel] = MAX_S;
          else
            score_d[bus.player_sel] = cur_s + (inc_two ? 4'd2 : 4'd1);
`ifdef SCORE_STREAK_EN
          // Any other player's hit breaks their streak.
          streak_d = '0;
          streak_d[bus.player_sel] = (streak_q[bus.player_sel] == 2'd3) ?
                                     2'd3 : streak_q[bus.player_sel] + 2'd1;
`endif
        end else if (miss_ev) begin
          if (cur_w - 6'sd1 < MIN_W)
            score_d[bus.player_sel] = MIN_S;
          else
            score_d[bus.player_sel] = cur_s - 4'd1;
`ifdef SCORE_STREAK_EN
          streak_d[bus.player_sel] = 2'd0;
`endif
        end
        // The in-cycle event above still lands when the round closes.
        if (bus.end_round || (TMO_EN && (tmo_q == TMO_LAST)))
          state_d = DONE;
      end
      DONE: begin
        if (bus.ack) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      // NOTE: the score array is reset explicitly because it drives the
      // visible outputs directly; it is not a RAM.
      score_q  <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
`ifdef SCORE_STREAK_EN
      streak_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      score_q  <= score_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
`ifdef SCORE_STREAK_EN
      streak_q <= streak_d;
`endif
    end
  end

  assign bus.p0         = score_q[0];
  assign bus.p1         = score_q[1];
  assign bus.p2         = score_q[2];
  assign bus.p3         = score_q[3];
  assign bus.p4         = score_q[4];
  assign bus.p5         = score_q[5];
  assign bus.p6         = score_q[6];
  assign bus.p7         = score_q[7];
  assign bus.busy       = (state_q == PLAY);
  assign bus.round_done = (state_q == DONE);
  assign bus.round_cnt  = cnt_q;

endmodule

// File: tb/tb_player_score_tracker.sv
// -----------------------------------------------------------------------------
// tb_player_score_tracker
//   Three instances: default bounds (main), ROUND_TIMEOUT=4 (timeout),
//   MAX_SCORE=7/MIN_SCORE=-8 (streak). The main instance is compared each
//   cycle against an integer-arithmetic model of the round rules.
// -----------------------------------------------------------------------------
module tb_player_score_tracker;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  player_score_if if0 ();
  player_score_if if1 ();
  player_score_if if2 ();

  player_score_tracker u_dut (.clk(clk), .reset_n(reset_n), .bus(if0));
  player_score_tracker #(.ROUND_TIMEOUT(4)) u_tmo (.clk(clk), .reset_n(reset_n), .bus(if1));
  player_score_tracker #(.MAX_SCORE(7), .MIN_SCORE(-8)) u_str (.clk(clk), .reset_n(reset_n), .bus(if2));

  int checks = 0;
  int errors = 0;

  // Model of the main instance: 0 idle, 1 play, 2 done.
  int m_score[8];
  int m_streak[8];
  int m_state;
  int m_rcnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_score[i]  = 0;
      m_streak[i] = 0;
    end
    m_state = 0;
    m_rcnt  = 0;
  endtask

  task automatic model_step(input bit st, input int sel, input bit h, input bit m,
                            input bit er, input bit ak);
    int inc;
    case (m_state)
      0: if (st) begin
        m_state = 1;
        for (int i = 0; i < 8; i++) begin
          m_score[i]  = 0;
          m_streak[i] = 0;
        end
      end
      1: begin
        if (h && !m) begin
          inc = 1;
`ifdef SCORE_STREAK_EN
          if (m_streak[sel] >= 2) inc = 2;
`endif
          for (int i = 0; i < 8; i++)
            if (i != sel) m_streak[i] = 0;
          if (m_streak[sel] < 3) m_streak[sel]++;
          m_score[sel] = (m_score[sel] + inc > 2) ? 2 : m_score[sel] + inc;
        end else if (m && !h) begin
          m_score[sel]  = (m_score[sel] - 1 < -2) ? -2 : m_score[sel] - 1;
          m_streak[sel] = 0;
        end
        if (er) m_state = 2;
      end
      default: if (ak) begin
        m_state = 0;
        m_rcnt  = (m_rcnt + 1) % 16;
      end
    endcase
  endtask

  function automatic logic [3:0] p_of(input int i);
    case (i)
      0: p_of = if0.p0;
      1: p_of = if0.p1;
      2: p_of = if0.p2;
      3: p_of = if0.p3;
      4: p_of = if0.p4;
      5: p_of = if0.p5;
      6: p_of = if0.p6;
      default: p_of = if0.p7;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {if0.start, if0.player_sel, if0.hit, if0.miss, if0.end_round, if0.ack} = '0;
    {if1.start, if1.player_sel, if1.hit, if1.miss, if1.end_round, if1.ack} = '0;
    {if2.start, if2.player_sel, if2.hit, if2.miss, if2.end_round, if2.ack} = '0;
  endtask

  // One cycle of stimulus on the main instance, model advanced alongside.
  task automatic drive0(input bit st, input int sel, input bit h, input bit m,
                        input bit er, input bit ak);
    if0.start = st; if0.player_sel = 3'(sel); if0.hit = h;
    if0.miss = m; if0.end_round = er; if0.ack = ak;
    tick();
    model_step(st, sel, h, m, er, ak);
    {if0.start, if0.hit, if0.miss, if0.end_round, if0.ack} = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (p_of(i) !== 4'd0) begin
        errors++; $display("FAIL reset_p%0d got %0h want 0", i, p_of(i));
      end
    end
    checks++;
    if ({if0.busy, if0.round_done, if0.round_cnt} !== 6'd0) begin
      errors++; $display("FAIL reset_status got busy=%b done=%b cnt=%0d want 0 0 0",
                          if0.busy, if0.round_done, if0.round_cnt);
    end
    checks++;
    if ({if1.busy, if2.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_other_busy got %b%b want 00", if1.busy, if2.busy);
    end
    reset_n = 1'b1;
    drive0(1, 0, 0, 0, 0, 0);
    checks++;
    if ({if0.busy, if0.round_done} !== 2'b10) begin
      errors++; $display("FAIL start_busy got busy=%b done=%b want 1 0", if0.busy, if0.round_done);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_hit [3]  = '{4'd1, 4'd2, 4'd2};
    logic [3:0] exp_miss [5] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE};
    for (int k = 0; k < 3; k++) begin
      drive0(0, 3, 1, 0, 0, 0);
      checks++;
      if (if0.p3 !== exp_hit[k]) begin
        errors++; $display("FAIL sat_hit%0d p3 got %0h want %0h", k, if0.p3, exp_hit[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      drive0(0, 0, 0, 1, 0, 0);
      checks++;
      if (if0.p0 !== exp_miss[k]) begin
        errors++; $display("FAIL sat_miss%0d p0 got %0h want %0h", k, if0.p0, exp_miss[k]);
      end
    end
    for (int i = 1; i < 8; i++) begin
      if (i == 3) continue;
      checks++;
      if (p_of(i) !== 4'd0) begin
        errors++; $display("FAIL sat_other_p%0d got %0h want 0", i, p_of(i));
      end
    end
  endtask

  task automatic test_hit_miss_end();
    drive0(0, 5, 1, 1, 0, 0);
    checks++;
    if (if0.p5 !== 4'd0) begin
      errors++; $display("FAIL hitmiss_p5 got %0h want 0", if0.p5);
    end
    drive0(0, 7, 1, 0, 1, 0);
    checks++;
    if ({if0.p7, if0.round_done, if0.busy} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL end_hit got p7=%0h done=%b busy=%b want 1 1 0",
                          if0.p7, if0.round_done, if0.busy);
    end
  endtask

  task automatic test_done_hold();
    logic [3:0] exp [8] = '{4'hE, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1};
    for (int k = 0; k < 3; k++) begin
      drive0(1, 1, 1, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (p_of(i) !== exp[i]) begin
          errors++; $display("FAIL done_hold%0d_p%0d got %0h want %0h", k, i, p_of(i), exp[i]);
        end
      end
      checks++;
      if (if0.round_done !== 1'b1) begin
        errors++; $display("FAIL done_hold%0d round_done got %b want 1", k, if0.round_done);
      end
    end
    drive0(0, 0, 0, 0, 0, 1);
    checks++;
    if ({if0.round_done, if0.busy, if0.round_cnt, if0.p3} !== {1'b0, 1'b0, 4'd1, 4'd2}) begin
      errors++; $display("FAIL ack got done=%b busy=%b cnt=%0d p3=%0h want 0 0 1 2",
                          if0.round_done, if0.busy, if0.round_cnt, if0.p3);
    end
    drive0(0, 0, 0, 0, 0, 1);
    checks++;
    if (if0.round_cnt !== 4'd1) begin
      errors++; $display("FAIL ack_idle cnt got %0d want 1", if0.round_cnt);
    end
  endtask

  task automatic test_round_wrap();
    for (int r = 2; r <= 16; r++) begin
      drive0(1, 0, 0, 0, 0, 0);
      drive0(0, 0, 0, 0, 1, 0);
      drive0(0, 0, 0, 0, 0, 1);
      checks++;
      if (if0.round_cnt !== 4'(r % 16)) begin
        errors++; $display("FAIL wrap_r%0d cnt got %0d want %0d", r, if0.round_cnt, r % 16);
      end
    end
  endtask

  task automatic test_random();
    bit st, h, m, er, ak;
    int sel;
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom % 4) == 0;
      sel = int'($urandom % 8);
      h   = ($urandom % 2) == 0;
      m   = ($urandom % 3) == 0;
      er  = (m_state == 1) ? (($urandom % 8) == 0) : (($urandom % 2) == 0);
      ak  = ($urandom % 3) == 0;
      drive0(st, sel, h, m, er, ak);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (p_of(i) !== 4'(m_score[i])) begin
          errors++; $display("FAIL rand_c%0d_p%0d got %0h want %0h", c, i, p_of(i), 4'(m_score[i]));
        end
      end
      checks++;
      if ({if0.busy, if0.round_done, if0.round_cnt} !==
          {m_state == 1, m_state == 2, 4'(m_rcnt)}) begin
        errors++; $display("FAIL rand_c%0d_status got busy=%b done=%b cnt=%0d want state %0d cnt %0d",
                            c, if0.busy, if0.round_done, if0.round_cnt, m_state, m_rcnt);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    checks++;
    if (if1.busy !== 1'b1) begin
      errors++; $display("FAIL tmo_busy got %b want 1", if1.busy);
    end
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (if1.round_done === 1'b1) begin
        seen = k;
        break;
      end
    end
    checks++;
    if (seen != 4) begin
      errors++; $display("FAIL tmo_latency got %0d cycles want 4 (0 = never)", seen);
    end
    if1.ack = 1'b1;
    tick();
    if1.ack = 1'b0;
    // Reset in the middle of a round with a non-zero score.
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    if1.player_sel = 3'd0;
    if1.hit = 1'b1;
    tick();
    if1.hit = 1'b0;
    checks++;
    if ({if1.p0, if1.busy} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL tmo_prereset got p0=%0h busy=%b want 1 1", if1.p0, if1.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({if1.p0, if1.busy, if1.round_done} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got p0=%0h busy=%b done=%b want 0 0 0",
                          if1.p0, if1.busy, if1.round_done);
    end
    model_reset();
    #1 reset_n = 1'b1;
    tick();
    checks++;
    if ({if1.round_done, if1.busy} !== 2'b00) begin
      errors++; $display("FAIL post_reset got done=%b busy=%b want 0 0", if1.round_done, if1.busy);
    end
  endtask

  task automatic test_streak();
`ifdef SCORE_STREAK_EN
    logic [3:0] exp [6] = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd5, 4'd6};
`else
    logic [3:0] exp [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd4};
`endif
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.player_sel = 3'd2;
    for (int k = 0; k < 6; k++) begin
      if2.hit  = (k != 4);
      if2.miss = (k == 4);
      tick();
      checks++;
      if (if2.p2 !== exp[k]) begin
        errors++; $display("FAIL streak_s%0d p2 got %0h want %0h", k, if2.p2, exp[k]);
      end
    end
    {if2.hit, if2.miss} = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_saturation();
    test_hit_miss_end();
    test_done_hold();
    test_round_wrap();
    test_random();
    test_timeout();
    test_streak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
